// File: rtl/rx_iq_byte_packer.sv
// Buffers strobed I/Q sample pairs in a small FIFO and serializes each pair into
// six bytes (I MSB first) on a valid/ready byte stream; counts dropped pairs.
module rx_iq_byte_packer #(
   parameter int unsigned IQ_WIDTH   = 24,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_strobe,
   input  logic [IQ_WIDTH-1:0]   in_I,
   input  logic [IQ_WIDTH-1:0]   in_Q,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_first,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [15:0]           overflow_count,
   input  logic                  clear_overflow
);

   localparam int unsigned PAIR_W = 2 * IQ_WIDTH;
   localparam int unsigned NBYTES = PAIR_W / 8;
   localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [2:0]          IDX_LAST = 3'(NBYTES - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   logic [PAIR_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [15:0]           r_ovf;
   state_e                r_state;
   logic [PAIR_W-1:0]     r_shift;
   logic [2:0]            r_idx;
   logic                  r_first;

   state_e w_state_nxt;
   logic   w_full;
   logic   w_nonempty;
   logic   w_wr;
   logic   w_drop;
   logic   w_pop;
   logic   w_accept;

   // Full is judged on the registered count, so a same-cycle pop cannot rescue a strobe.
   assign w_full     = (r_count == CNT_FULL);
   assign w_nonempty = (r_count != '0);
   assign w_wr       = in_strobe && !w_full;
   assign w_drop     = in_strobe && w_full;
   assign w_accept   = (r_state == StSend) && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_nonempty) begin
               w_pop       = 1'b1;
               w_state_nxt = StSend;
            end
         end
         StSend: begin
            if (out_ready && (r_idx == IDX_LAST)) begin
               if (w_nonempty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {in_I, in_Q};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_wr) begin
            r_count <= r_count - CNT_ONE;
         end
         if (clear_overflow) begin
            r_ovf <= '0;
         end else if (w_drop && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 16'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_idx   <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // A reload on the last accepted byte takes priority over the shift: no bubble.
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_idx   <= '0;
            r_first <= 1'b1;
         end else if (w_accept) begin
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + 3'd1;
            r_first <= 1'b0;
         end
      end
   end

   assign out_valid      = (r_state == StSend);
   assign out_data       = out_valid ? r_shift[PAIR_W-1 -: 8] : 8'h00;
   assign out_first      = out_valid && r_first;
   assign fifo_count     = r_count;
   assign overflow_count = r_ovf;

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
// Bench for rx_iq_byte_packer: table vectors, hand-written corner sequences and a
// randomized run, all checked against a queue-based model of the byte stream.
module tb_rx_iq_byte_packer;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_strobe = 1'b0;
   logic [23:0] in_I = '0;
   logic [23:0] in_Q = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_first;
   logic [4:0]  fifo_count;
   logic [15:0] overflow_count;
   logic        clear_overflow = 1'b0;

   always #5 clock = ~clock;

   rx_iq_byte_packer #(
      .IQ_WIDTH   (24),
      .DEPTH_LOG2 (4)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_strobe      (in_strobe),
      .in_I           (in_I),
      .in_Q           (in_Q),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_first      (out_first),
      .fifo_count     (fifo_count),
      .overflow_count (overflow_count),
      .clear_overflow (clear_overflow)
   );

   typedef struct {
      logic [23:0] i;
      logic [23:0] q;
      logic [47:0] exp;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Model: bytes still owed to the consumer, pairs accepted, bytes handed over.
   logic [7:0]  m_q[$];
   int          m_pushed;
   int          m_bytes_acc;
   logic [15:0] m_ovf;
   logic        m_hs;
   logic [7:0]  m_byte;
   logic        m_prev_stall;
   logic [7:0]  m_prev_data;
   logic        m_prev_first;
   int          m_run;
   int          m_max_run;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_pushed     = 0;
      m_bytes_acc  = 0;
      m_ovf        = '0;
      m_hs         = 1'b0;
      m_byte       = '0;
      m_prev_stall = 1'b0;
      m_prev_data  = '0;
      m_prev_first = 1'b0;
      m_run        = 0;
      m_max_run    = 0;
   endtask

   // Drive one clock cycle of inputs, check the DUT against the model, then step.
   task automatic cycle(input logic stb, input logic [23:0] ii, input logic [23:0] qq,
                        input logic rdy, input logic clr);
      int         loaded;
      int         occ;
      logic [7:0] exp_b;
      logic       exp_first;
      in_strobe      = stb;
      in_I           = ii;
      in_Q           = qq;
      out_ready      = rdy;
      clear_overflow = clr;
      // Pairs taken by the serializer: any partially sent, plus a fresh one on display.
      loaded = (m_bytes_acc + 5) / 6 + ((out_valid === 1'b1 && (m_bytes_acc % 6) == 0) ? 1 : 0);
      occ    = m_pushed - loaded;
      chk("fifo_count", 64'(fifo_count), 64'(occ));
      chk("overflow_count", 64'(overflow_count), 64'(m_ovf));
      if (out_valid !== 1'b1) begin
         chk("idle_outputs_zero", 64'({out_data, out_first}), 64'd0);
      end
      if (m_prev_stall) begin
         chk("stall_valid_held", 64'(out_valid), 64'd1);
         chk("stall_data_held", 64'(out_data), 64'(m_prev_data));
         chk("stall_first_held", 64'(out_first), 64'(m_prev_first));
      end
      if (out_valid === 1'b1) m_run++;
      else m_run = 0;
      if (m_run > m_max_run) m_max_run = m_run;
      m_hs = (out_valid === 1'b1) && rdy;
      if (m_hs) begin
         exp_first = ((m_bytes_acc % 6) == 0);
         if (m_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no byte at %0t", out_data, $time);
         end else begin
            exp_b = m_q.pop_front();
            chk("byte", 64'(out_data), 64'(exp_b));
            chk("first", 64'(out_first), 64'(exp_first));
         end
         m_byte = out_data;
         m_bytes_acc++;
      end
      m_prev_stall = (out_valid === 1'b1) && !rdy;
      m_prev_data  = out_data;
      m_prev_first = out_first;
      if (stb) begin
         if (occ >= DEPTH) begin
            if (m_ovf != 16'hFFFF) m_ovf++;
         end else begin
            m_pushed++;
            m_q.push_back(ii[23:16]);
            m_q.push_back(ii[15:8]);
            m_q.push_back(ii[7:0]);
            m_q.push_back(qq[23:16]);
            m_q.push_back(qq[15:8]);
            m_q.push_back(qq[7:0]);
         end
      end
      if (clr) m_ovf = '0;
      @(posedge clock);
      #1;
   endtask

   // Asynchronous reset asserted wherever we currently are; outputs must clear at once.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_first", 64'(out_first), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_overflow", 64'(overflow_count), 64'd0);
      model_clear();
      in_strobe      = 1'b0;
      out_ready      = 1'b0;
      clear_overflow = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((m_q.size() != 0 || out_valid === 1'b1) && n < budget) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
         n++;
      end
      chk({name, "_drained"}, 64'(m_q.size()), 64'd0);
   endtask

   vec_t        tbl[4];
   logic [47:0] col;
   int          nb;
   int          acc0;

   initial begin
      tbl[0] = '{i: 24'h123456, q: 24'hABCDEF, exp: 48'h12_34_56_AB_CD_EF};
      tbl[1] = '{i: 24'h800000, q: 24'h7FFFFF, exp: 48'h80_00_00_7F_FF_FF};
      tbl[2] = '{i: 24'hFFFFFF, q: 24'h000000, exp: 48'hFF_FF_FF_00_00_00};
      tbl[3] = '{i: 24'h000001, q: 24'hFFFFFE, exp: 48'h00_00_01_FF_FF_FE};
      model_clear();
      @(posedge clock);
      #2;
      do_reset();

      // Single pairs from the table, with latency check on each.
      foreach (tbl[k]) begin
         cycle(1'b1, tbl[k].i, tbl[k].q, 1'b1, 1'b0);
         chk("latency_write_edge", 64'(out_valid), 64'd0);
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
         chk("latency_pop_edge", 64'(out_valid), 64'd1);
         col = '0;
         nb  = 0;
         for (int c = 0; c < 10; c++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            if (m_hs) begin
               col = {col[39:0], m_byte};
               nb++;
            end
         end
         chk("table_byte_count", 64'(nb), 64'd6);
         chk("table_bytes", 64'(col), 64'(tbl[k].exp));
         chk("table_valid_low", 64'(out_valid), 64'd0);
         chk("table_fifo_empty", 64'(fifo_count), 64'd0);
      end

      // Backpressure: ready pattern 1,0,0 repeating.
      do_reset();
      cycle(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
      col = '0;
      nb  = 0;
      for (int c = 0; c < 40; c++) begin
         cycle(1'b0, '0, '0, (c % 3) == 0, 1'b0);
         if (m_hs) begin
            col = {col[39:0], m_byte};
            nb++;
         end
      end
      chk("bp_handshakes", 64'(nb), 64'd6);
      chk("bp_bytes", 64'(col), 64'h12_34_56_AB_CD_EF);

      // Back-to-back pairs must stream 18 bytes with no gap.
      do_reset();
      cycle(1'b1, 24'h000001, 24'h000002, 1'b1, 1'b0);
      cycle(1'b1, 24'h000003, 24'h000004, 1'b1, 1'b0);
      cycle(1'b1, 24'h000005, 24'h000006, 1'b1, 1'b0);
      drain("b2b", 40);
      chk("b2b_contiguous", 64'(m_max_run), 64'd18);
      chk("b2b_bytes", 64'(m_bytes_acc), 64'd18);

      // Overflow: 20 strobes with the consumer stalled.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b1, 24'(k), 24'(k + 256), 1'b0, 1'b0);
      end
      chk("ovf_fifo_full", 64'(fifo_count), 64'd16);
      chk("ovf_count", 64'(overflow_count), 64'd3);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(overflow_count), 64'd0);
      acc0 = m_bytes_acc;
      drain("ovf", 300);
      chk("ovf_pairs_out", 64'((m_bytes_acc - acc0) / 6), 64'd17);

      // Saturation, then a drop coinciding with clear.
      do_reset();
      for (int k = 0; k < 17 + 65540; k++) begin
         cycle(1'b1, 24'(k), 24'(~k), 1'b0, 1'b0);
      end
      chk("sat_value", 64'(overflow_count), 64'hFFFF);
      cycle(1'b1, 24'h0, 24'h0, 1'b0, 1'b1);
      chk("sat_clear_wins", 64'(overflow_count), 64'd0);
      drain("sat", 300);

      // Reset mid-frame after byte 2 with 4 pairs still queued.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 24'(k * 3 + 7), 24'(k * 5 + 9), 1'b0, 1'b0);
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      chk("midrst_queued", 64'(fifo_count), 64'd4);
      repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
      #2;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         chk("midrst_quiet", 64'(out_valid), 64'd0);
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
      end
      cycle(1'b1, 24'hC0FFEE, 24'h5A5A5A, 1'b1, 1'b0);
      col = '0;
      nb  = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
         if (m_hs) begin
            col = {col[39:0], m_byte};
            nb++;
         end
      end
      chk("midrst_new_pair", 64'(col), 64'hC0_FF_EE_5A_5A_5A);
      chk("midrst_new_count", 64'(nb), 64'd6);

      // Randomized traffic with varying consumer throughput.
      do_reset();
      for (int s = 0; s < 30; s++) begin
         int p_rdy;
         p_rdy = $urandom_range(0, 4);
         for (int c = 0; c < 100; c++) begin
            cycle($urandom_range(0, 3) == 0, 24'($urandom), 24'($urandom),
                  $urandom_range(0, 3) < p_rdy, $urandom_range(0, 63) == 0);
         end
      end
      drain("rand", 400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
